// File: rtl/match_scoreboard_pkg.sv
// Shared definitions for the match scoreboard: default widths and issue FSM states.
// These defaults stand in for the ADDR_WIDTH, MAX_MATCH_LEN_LOG2 and
// MATCH_SB_CAND_NUM settings used across the match PE pipeline.
package match_scoreboard_pkg;

    localparam int DEF_ADDR_WIDTH         = 16;
    localparam int DEF_MAX_MATCH_LEN_LOG2 = 5;
    localparam int DEF_MATCH_SB_CAND_NUM  = 4;
    localparam int DEF_ENTRY_INDEX        = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } issue_state_e;

endpackage

// File: rtl/match_scoreboard_cand_next_sel.sv
// cand_next_sel: finds the lowest set mask bit strictly above the current index.
// 'none' is raised when no such bit exists; next_idx is then 0.
module cand_next_sel #(
    parameter int CAND_NUM = 4,
    parameter int CW       = $clog2(CAND_NUM)
) (
    input  logic [CAND_NUM-1:0] mask,
    input  logic [CW-1:0]       cur,
    output logic [CW-1:0]       next_idx,
    output logic                none
);

    // Scan from the top down so the lowest qualifying bit is the last one written
    always_comb begin
        next_idx = '0;
        none     = 1'b1;
        for (int c = CAND_NUM - 1; c >= 0; c--) begin
            if (mask[c] && (c > int'(cur))) begin
                next_idx = CW'(c);
                none     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/match_scoreboard.sv
// match_scoreboard: issues match job candidates to the PE, collects returned
// lengths per scoreboard entry and retires jobs in acceptance order.
// Optional feature macro: MATCH_SB_STATS_EN adds o_stat_jobs / o_stat_zero counters.
module match_scoreboard
    import match_scoreboard_pkg::*;
#(
    parameter int SCOREBOARD_ENTRY_INDEX = DEF_ENTRY_INDEX,
    parameter int CAND_NUM               = DEF_MATCH_SB_CAND_NUM,
    parameter int ADDR_WIDTH             = DEF_ADDR_WIDTH,
    parameter int MAX_MATCH_LEN_LOG2     = DEF_MAX_MATCH_LEN_LOG2,
    localparam int CW      = $clog2(CAND_NUM),
    localparam int IW      = SCOREBOARD_ENTRY_INDEX,
    localparam int ENTRIES = 2 ** SCOREBOARD_ENTRY_INDEX,
    localparam int LW      = MAX_MATCH_LEN_LOG2 + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_job_valid,
    output logic                         o_job_ready,
    input  logic [ADDR_WIDTH-1:0]        i_job_head_addr,
    input  logic [CAND_NUM*ADDR_WIDTH-1:0] i_job_hist_addr,
    input  logic [CAND_NUM-1:0]          i_job_hist_mask,
    output logic                         o_pe_valid,
    output logic                         o_pe_last,
    output logic [IW-1:0]                o_pe_idx,
    output logic [ADDR_WIDTH-1:0]        o_pe_head_addr,
    output logic [ADDR_WIDTH-1:0]        o_pe_history_addr,
    input  logic                         i_pe_valid,
    input  logic                         i_pe_last,
    input  logic [IW-1:0]                i_pe_idx,
    input  logic [LW-1:0]                i_pe_match_len,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [LW-1:0]                o_res_match_len,
    output logic [CW-1:0]                o_res_cand,
`ifdef MATCH_SB_STATS_EN
    output logic [ADDR_WIDTH-1:0]        o_res_hist_addr,
    output logic [31:0]                  o_stat_jobs,
    output logic [31:0]                  o_stat_zero
`else
    output logic [ADDR_WIDTH-1:0]        o_res_hist_addr
`endif
);

    // Per-entry job state
    logic [ADDR_WIDTH-1:0]          head_q [ENTRIES];
    logic [ADDR_WIDTH-1:0]          head_d [ENTRIES];
    logic [CAND_NUM*ADDR_WIDTH-1:0] hist_q [ENTRIES];
    logic [CAND_NUM*ADDR_WIDTH-1:0] hist_d [ENTRIES];
    logic [CAND_NUM-1:0]            mask_q [ENTRIES];
    logic [CAND_NUM-1:0]            mask_d [ENTRIES];
    logic [LW-1:0]                  best_len_q [ENTRIES];
    logic [LW-1:0]                  best_len_d [ENTRIES];
    logic [CW-1:0]                  best_cand_q [ENTRIES];
    logic [CW-1:0]                  best_cand_d [ENTRIES];
    logic [CW-1:0]                  res_cur_q [ENTRIES];
    logic [CW-1:0]                  res_cur_d [ENTRIES];
    logic [ENTRIES-1:0]             done_q, done_d;
    logic [ENTRIES-1:0]             alloc_q, alloc_d;

    // Pointers and occupancy
    logic [IW-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [IW-1:0] ret_ptr_q, ret_ptr_d;
    logic [IW:0]   count_q, count_d;

    // Issue FSM and registered PE request
    issue_state_e          state_q, state_d;
    logic [IW-1:0]         iss_idx_q, iss_idx_d;
    logic [CW-1:0]         iss_cur_q, iss_cur_d;
    logic                  pe_valid_q, pe_valid_d;
    logic                  pe_last_q, pe_last_d;
    logic [IW-1:0]         pe_idx_q, pe_idx_d;
    logic [ADDR_WIDTH-1:0] pe_head_q, pe_head_d;
    logic [ADDR_WIDTH-1:0] pe_hist_q, pe_hist_d;

    // Handshake and cursor helpers
    logic          accept;
    logic          retire;
    logic          res_hit;
    logic          job_mask_empty;
    logic [CW-1:0] low_idx;
    logic          low_none;
    logic [CW-1:0] first_idx;
    logic [CW-1:0] after_first_idx;
    logic          after_first_none;
    logic [CW-1:0] nxt_idx;
    logic          nxt_none;
    logic [CW-1:0] nxt2_idx;
    logic          nxt2_none;
    logic [CW-1:0] res_next_idx;
    logic          res_next_none;
    logic [CAND_NUM*ADDR_WIDTH-1:0] ret_hist;
    logic          unused_sel;

    // Lowest set bit of the incoming mask (bit 0 is checked directly)
    cand_next_sel #(.CAND_NUM(CAND_NUM), .CW(CW)) u_sel_low (
        .mask     (i_job_hist_mask),
        .cur      ('0),
        .next_idx (low_idx),
        .none     (low_none)
    );

    assign job_mask_empty = !i_job_hist_mask[0] && low_none;
    assign first_idx      = i_job_hist_mask[0] ? '0 : low_idx;

    // Whether the first candidate of an incoming job is also its last
    cand_next_sel #(.CAND_NUM(CAND_NUM), .CW(CW)) u_sel_after_first (
        .mask     (i_job_hist_mask),
        .cur      (first_idx),
        .next_idx (after_first_idx),
        .none     (after_first_none)
    );

    // Next candidate of the job currently being issued
    cand_next_sel #(.CAND_NUM(CAND_NUM), .CW(CW)) u_sel_issue (
        .mask     (mask_q[iss_idx_q]),
        .cur      (iss_cur_q),
        .next_idx (nxt_idx),
        .none     (nxt_none)
    );

    // Lookahead: is the next issued candidate the highest set bit
    cand_next_sel #(.CAND_NUM(CAND_NUM), .CW(CW)) u_sel_issue_last (
        .mask     (mask_q[iss_idx_q]),
        .cur      (nxt_idx),
        .next_idx (nxt2_idx),
        .none     (nxt2_none)
    );

    // Result cursor advance for the entry named by the incoming PE result
    cand_next_sel #(.CAND_NUM(CAND_NUM), .CW(CW)) u_sel_result (
        .mask     (mask_q[i_pe_idx]),
        .cur      (res_cur_q[i_pe_idx]),
        .next_idx (res_next_idx),
        .none     (res_next_none)
    );

    assign unused_sel = ^{after_first_idx, nxt2_idx};

    // Ready depends only on registered state; full blocks ready even during a retire
    always_comb begin
        o_job_ready = (state_q == ST_IDLE) && (count_q < (IW+1)'(ENTRIES));
        accept      = i_job_valid && o_job_ready;
    end

    // Issue FSM: load the first candidate on accept, then walk the mask one per cycle
    always_comb begin
        state_d    = state_q;
        iss_idx_d  = iss_idx_q;
        iss_cur_d  = iss_cur_q;
        pe_valid_d = 1'b0;
        pe_last_d  = 1'b0;
        pe_idx_d   = pe_idx_q;
        pe_head_d  = pe_head_q;
        pe_hist_d  = pe_hist_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !job_mask_empty) begin
                    state_d    = ST_ISSUE;
                    iss_idx_d  = alloc_ptr_q;
                    iss_cur_d  = first_idx;
                    pe_valid_d = 1'b1;
                    pe_last_d  = after_first_none;
                    pe_idx_d   = alloc_ptr_q;
                    pe_head_d  = i_job_head_addr;
                    pe_hist_d  = i_job_hist_addr[first_idx*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
            ST_ISSUE: begin
                if (pe_last_q || nxt_none) begin
                    state_d = ST_IDLE;
                end else begin
                    iss_cur_d  = nxt_idx;
                    pe_valid_d = 1'b1;
                    pe_last_d  = nxt2_none;
                    pe_idx_d   = iss_idx_q;
                    pe_head_d  = head_q[iss_idx_q];
                    pe_hist_d  = hist_q[iss_idx_q][nxt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Retirement view of the entry at the retire pointer
    always_comb begin
        ret_hist        = hist_q[ret_ptr_q];
        o_res_valid     = done_q[ret_ptr_q] && alloc_q[ret_ptr_q];
        o_res_match_len = best_len_q[ret_ptr_q];
        o_res_cand      = best_cand_q[ret_ptr_q];
        o_res_hist_addr = ret_hist[best_cand_q[ret_ptr_q]*ADDR_WIDTH +: ADDR_WIDTH];
        retire          = o_res_valid && i_res_ready;
        res_hit         = i_pe_valid && alloc_q[i_pe_idx];
    end

    // Entry updates: allocate on accept, absorb PE results, free on retire
    always_comb begin
        head_d      = head_q;
        hist_d      = hist_q;
        mask_d      = mask_q;
        best_len_d  = best_len_q;
        best_cand_d = best_cand_q;
        res_cur_d   = res_cur_q;
        done_d      = done_q;
        alloc_d     = alloc_q;
        alloc_ptr_d = alloc_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        count_d     = count_q;

        if (accept) begin
            head_d[alloc_ptr_q]      = i_job_head_addr;
            hist_d[alloc_ptr_q]      = i_job_hist_addr;
            mask_d[alloc_ptr_q]      = i_job_hist_mask;
            best_len_d[alloc_ptr_q]  = '0;
            best_cand_d[alloc_ptr_q] = '0;
            res_cur_d[alloc_ptr_q]   = first_idx;
            done_d[alloc_ptr_q]      = job_mask_empty;
            alloc_d[alloc_ptr_q]     = 1'b1;
            alloc_ptr_d              = alloc_ptr_q + IW'(1);
        end

        if (res_hit) begin
            if (i_pe_match_len > best_len_q[i_pe_idx]) begin
                best_len_d[i_pe_idx]  = i_pe_match_len;
                best_cand_d[i_pe_idx] = res_cur_q[i_pe_idx];
            end
            if (!res_next_none) begin
                res_cur_d[i_pe_idx] = res_next_idx;
            end
            if (i_pe_last) begin
                done_d[i_pe_idx] = 1'b1;
            end
        end

        if (retire) begin
            alloc_d[ret_ptr_q] = 1'b0;
            done_d[ret_ptr_q]  = 1'b0;
            ret_ptr_d          = ret_ptr_q + IW'(1);
        end

        case ({accept, retire})
            2'b10:   count_d = count_q + (IW+1)'(1);
            2'b01:   count_d = count_q - (IW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State register for the FSM, pointers, PE request and entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            iss_idx_q   <= '0;
            iss_cur_q   <= '0;
            pe_valid_q  <= 1'b0;
            pe_last_q   <= 1'b0;
            pe_idx_q    <= '0;
            pe_head_q   <= '0;
            pe_hist_q   <= '0;
            alloc_ptr_q <= '0;
            ret_ptr_q   <= '0;
            count_q     <= '0;
            done_q      <= '0;
            alloc_q     <= '0;
            for (int e = 0; e < ENTRIES; e++) begin
                head_q[e]      <= '0;
                hist_q[e]      <= '0;
                mask_q[e]      <= '0;
                best_len_q[e]  <= '0;
                best_cand_q[e] <= '0;
                res_cur_q[e]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            iss_idx_q   <= iss_idx_d;
            iss_cur_q   <= iss_cur_d;
            pe_valid_q  <= pe_valid_d;
            pe_last_q   <= pe_last_d;
            pe_idx_q    <= pe_idx_d;
            pe_head_q   <= pe_head_d;
            pe_hist_q   <= pe_hist_d;
            alloc_ptr_q <= alloc_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
            alloc_q     <= alloc_d;
            for (int e = 0; e < ENTRIES; e++) begin
                head_q[e]      <= head_d[e];
                hist_q[e]      <= hist_d[e];
                mask_q[e]      <= mask_d[e];
                best_len_q[e]  <= best_len_d[e];
                best_cand_q[e] <= best_cand_d[e];
                res_cur_q[e]   <= res_cur_d[e];
            end
        end
    end

    assign o_pe_valid        = pe_valid_q;
    assign o_pe_last         = pe_last_q;
    assign o_pe_idx          = pe_idx_q;
    assign o_pe_head_addr    = pe_head_q;
    assign o_pe_history_addr = pe_hist_q;

`ifdef MATCH_SB_STATS_EN
    logic [31:0] stat_jobs_q, stat_jobs_d;
    logic [31:0] stat_zero_q, stat_zero_d;

    // Count accepted jobs and retired jobs whose best length stayed zero
    always_comb begin
        stat_jobs_d = stat_jobs_q;
        stat_zero_d = stat_zero_q;
        if (accept) begin
            stat_jobs_d = stat_jobs_q + 32'd1;
        end
        if (retire && (o_res_match_len == '0)) begin
            stat_zero_d = stat_zero_q + 32'd1;
        end
    end

    // Statistic counter registers, wrapping naturally at 32 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_jobs_q <= '0;
            stat_zero_q <= '0;
        end else begin
            stat_jobs_q <= stat_jobs_d;
            stat_zero_q <= stat_zero_d;
        end
    end

    assign o_stat_jobs = stat_jobs_q;
    assign o_stat_zero = stat_zero_q;
`endif

endmodule

// File: tb/tb_match_scoreboard.sv
// Scoreboard testbench for match_scoreboard: expected PE requests and
// retirements are queued as jobs are issued and checked by monitors.
module tb_match_scoreboard;

    localparam int AW = 16;
    localparam int LW = 6;
    localparam int IW = 2;
    localparam int CN = 4;
    localparam int CW = 2;

    logic              clk;
    logic              rst_n;
    logic              i_job_valid;
    logic              o_job_ready;
    logic [AW-1:0]     i_job_head_addr;
    logic [CN*AW-1:0]  i_job_hist_addr;
    logic [CN-1:0]     i_job_hist_mask;
    logic              o_pe_valid;
    logic              o_pe_last;
    logic [IW-1:0]     o_pe_idx;
    logic [AW-1:0]     o_pe_head_addr;
    logic [AW-1:0]     o_pe_history_addr;
    logic              i_pe_valid;
    logic              i_pe_last;
    logic [IW-1:0]     i_pe_idx;
    logic [LW-1:0]     i_pe_match_len;
    logic              o_res_valid;
    logic              i_res_ready;
    logic [LW-1:0]     o_res_match_len;
    logic [CW-1:0]     o_res_cand;
    logic [AW-1:0]     o_res_hist_addr;
`ifdef MATCH_SB_STATS_EN
    logic [31:0]       o_stat_jobs;
    logic [31:0]       o_stat_zero;
`endif

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          last;
        logic [AW-1:0] head;
        logic [AW-1:0] hist;
    } pe_exp_t;

    typedef struct packed {
        logic [LW-1:0] len;
        logic [CW-1:0] cand;
        logic [AW-1:0] addr;
    } res_exp_t;

    pe_exp_t  pe_q[$];
    res_exp_t res_q[$];
    int nvec     = 0;
    int nfail    = 0;
    int tb_alloc = 0;

    match_scoreboard #(
        .SCOREBOARD_ENTRY_INDEX (IW),
        .CAND_NUM               (CN),
        .ADDR_WIDTH             (AW),
        .MAX_MATCH_LEN_LOG2     (LW - 1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_job_valid       (i_job_valid),
        .o_job_ready       (o_job_ready),
        .i_job_head_addr   (i_job_head_addr),
        .i_job_hist_addr   (i_job_hist_addr),
        .i_job_hist_mask   (i_job_hist_mask),
        .o_pe_valid        (o_pe_valid),
        .o_pe_last         (o_pe_last),
        .o_pe_idx          (o_pe_idx),
        .o_pe_head_addr    (o_pe_head_addr),
        .o_pe_history_addr (o_pe_history_addr),
        .i_pe_valid        (i_pe_valid),
        .i_pe_last         (i_pe_last),
        .i_pe_idx          (i_pe_idx),
        .i_pe_match_len    (i_pe_match_len),
        .o_res_valid       (o_res_valid),
        .i_res_ready       (i_res_ready),
        .o_res_match_len   (o_res_match_len),
        .o_res_cand        (o_res_cand),
`ifdef MATCH_SB_STATS_EN
        .o_res_hist_addr   (o_res_hist_addr),
        .o_stat_jobs       (o_stat_jobs),
        .o_stat_zero       (o_stat_zero)
`else
        .o_res_hist_addr   (o_res_hist_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck design never hangs the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CN*AW-1:0] mkHist(input logic [AW-1:0] base);
        logic [CN*AW-1:0] h;
        h = '0;
        for (int c = 0; c < CN; c++) begin
            h[c*AW +: AW] = base + AW'(c);
        end
        return h;
    endfunction

    // Queue the PE requests a job should produce and claim its entry index
    task automatic pushJob(input logic [AW-1:0] head, input logic [CN*AW-1:0] hist,
                           input logic [CN-1:0] mask, output logic [IW-1:0] idx);
        int hi;
        pe_exp_t e;
        hi = -1;
        idx = IW'(tb_alloc);
        for (int c = 0; c < CN; c++) begin
            if (mask[c]) hi = c;
        end
        for (int c = 0; c < CN; c++) begin
            if (mask[c]) begin
                e.idx  = idx;
                e.last = (c == hi);
                e.head = head;
                e.hist = hist[c*AW +: AW];
                pe_q.push_back(e);
            end
        end
        tb_alloc = (tb_alloc + 1) % 4;
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (!o_job_ready && n < 50) begin
            tick();
            n++;
        end
        checkOutput("job_ready_wait", 64'(o_job_ready), 64'd1);
    endtask

    // Offer a job once ready and return in the cycle after acceptance
    task automatic applyStimulus(input logic [AW-1:0] head, input logic [CN*AW-1:0] hist,
                                 input logic [CN-1:0] mask, output logic [IW-1:0] idx);
        waitReady();
        pushJob(head, hist, mask, idx);
        i_job_head_addr = head;
        i_job_hist_addr = hist;
        i_job_hist_mask = mask;
        i_job_valid     = 1'b1;
        tick();
        i_job_valid     = 1'b0;
    endtask

    task automatic peReturn(input logic [IW-1:0] idx, input logic [LW-1:0] len, input logic last);
        i_pe_valid     = 1'b1;
        i_pe_idx       = idx;
        i_pe_match_len = len;
        i_pe_last      = last;
        tick();
        i_pe_valid     = 1'b0;
        i_pe_last      = 1'b0;
    endtask

    task automatic pushRes(input logic [LW-1:0] len, input logic [CW-1:0] cand, input logic [AW-1:0] addr);
        res_exp_t r;
        r.len  = len;
        r.cand = cand;
        r.addr = addr;
        res_q.push_back(r);
    endtask

    // Monitor: every PE request and every retirement handshake is popped and compared
    always @(negedge clk) begin
        if (rst_n && o_pe_valid) begin
            if (pe_q.size() == 0) begin
                checkOutput("pe_unexpected", 64'd1, 64'd0);
            end else begin
                pe_exp_t pe_e;
                pe_e = pe_q.pop_front();
                checkOutput("pe_req", 64'({o_pe_idx, o_pe_last, o_pe_head_addr, o_pe_history_addr}), 64'(pe_e));
            end
        end
        if (rst_n && o_res_valid && i_res_ready) begin
            if (res_q.size() == 0) begin
                checkOutput("res_unexpected", 64'd1, 64'd0);
            end else begin
                res_exp_t res_e;
                res_e = res_q.pop_front();
                checkOutput("res_retire", 64'({o_res_match_len, o_res_cand, o_res_hist_addr}), 64'(res_e));
            end
        end
    end

    initial begin
        logic [IW-1:0] idx;
        logic [IW-1:0] idx_a;
        logic [IW-1:0] idx_b;
        logic [IW-1:0] job_idx[5];
        logic [IW-1:0] stale1;
        logic [IW-1:0] stale2;

        rst_n           = 1'b0;
        i_job_valid     = 1'b0;
        i_job_head_addr = '0;
        i_job_hist_addr = '0;
        i_job_hist_mask = '0;
        i_pe_valid      = 1'b0;
        i_pe_last       = 1'b0;
        i_pe_idx        = '0;
        i_pe_match_len  = '0;
        i_res_ready     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        checkOutput("rst_job_ready", 64'(o_job_ready), 64'd1);
        checkOutput("rst_pe_valid", 64'(o_pe_valid), 64'd0);
        checkOutput("rst_pe_last", 64'(o_pe_last), 64'd0);
        checkOutput("rst_res_valid", 64'(o_res_valid), 64'd0);
        checkOutput("rst_res_len", 64'(o_res_match_len), 64'd0);
        checkOutput("rst_pe_hist", 64'(o_pe_history_addr), 64'd0);

        // Single job, mask 1011, lengths 3,7,7: best is 7 from candidate 1
        $display("[TB] single job, mask 1011");
        i_res_ready = 1'b1;
        applyStimulus(16'h1000, mkHist(16'hA000), 4'b1011, idx);
        pushRes(6'd7, 2'd1, 16'hA001);
        checkOutput("t1_ready_busy1", 64'(o_job_ready), 64'd0);
        tick();
        i_pe_valid = 1'b1; i_pe_idx = idx; i_pe_match_len = 6'd3; i_pe_last = 1'b0;
        tick();
        i_pe_match_len = 6'd7;
        checkOutput("t1_ready_busy3", 64'(o_job_ready), 64'd0);
        tick();
        checkOutput("t1_ready_back", 64'(o_job_ready), 64'd1);
        i_pe_match_len = 6'd7; i_pe_last = 1'b1;
        tick();
        i_pe_valid = 1'b0; i_pe_last = 1'b0;
        checkOutput("t1_res_valid", 64'(o_res_valid), 64'd1);
        tick();

        // Empty-mask job retires the following cycle with length 0
        $display("[TB] empty-mask job");
        applyStimulus(16'h2000, mkHist(16'hB000), 4'b0000, idx);
        pushRes(6'd0, 2'd0, 16'hB000);
        checkOutput("t2_res_valid", 64'(o_res_valid), 64'd1);
        checkOutput("t2_job_ready", 64'(o_job_ready), 64'd1);
        checkOutput("t2_pe_valid", 64'(o_pe_valid), 64'd0);
        tick();

        // Fill all four entries with retirement held off, then free one
        $display("[TB] full scoreboard");
        i_res_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(16'h3000 + AW'(j), mkHist(16'hC000 + AW'(j * 16)), 4'b0100, job_idx[j]);
            pushRes(LW'(j + 1), 2'd2, 16'hC002 + AW'(j * 16));
            peReturn(job_idx[j], LW'(j + 1), 1'b1);
        end
        checkOutput("t3_full_ready", 64'(o_job_ready), 64'd0);
        checkOutput("t3_head_done", 64'(o_res_valid), 64'd1);
        pushJob(16'h3004, mkHist(16'hC040), 4'b0100, job_idx[4]);
        i_job_head_addr = 16'h3004;
        i_job_hist_addr = mkHist(16'hC040);
        i_job_hist_mask = 4'b0100;
        i_job_valid     = 1'b1;
        i_res_ready     = 1'b1;
        checkOutput("t3_full_retire_ready", 64'(o_job_ready), 64'd0);
        tick();
        i_res_ready = 1'b0;
        checkOutput("t3_ready_after_retire", 64'(o_job_ready), 64'd1);
        tick();
        i_job_valid = 1'b0;
        checkOutput("t3_fifth_issued", 64'(o_pe_valid), 64'd1);
        pushRes(6'd6, 2'd2, 16'hC042);
        peReturn(job_idx[4], 6'd6, 1'b1);
        i_res_ready = 1'b1;
        repeat (8) tick();

        // Job B completes before job A but must retire after it
        $display("[TB] out-of-order completion");
        applyStimulus(16'h4000, mkHist(16'hD000), 4'b0011, idx_a);
        applyStimulus(16'h4100, mkHist(16'hD100), 4'b0001, idx_b);
        pushRes(6'd9, 2'd1, 16'hD001);
        pushRes(6'd4, 2'd0, 16'hD100);
        peReturn(idx_b, 6'd4, 1'b1);
        checkOutput("t4_b_held", 64'(o_res_valid), 64'd0);
        peReturn(idx_a, 6'd2, 1'b0);
        peReturn(idx_a, 6'd9, 1'b1);
        checkOutput("t4_a_valid", 64'(o_res_valid), 64'd1);
        checkOutput("t4_a_len", 64'(o_res_match_len), 64'd9);
        repeat (4) tick();

        // Reset with two jobs in flight, then stale results must be ignored
        $display("[TB] reset mid-operation");
        applyStimulus(16'h5000, mkHist(16'hE000), 4'b0001, stale1);
        applyStimulus(16'h5100, mkHist(16'hE100), 4'b0001, stale2);
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tb_alloc = 0;
        checkOutput("t5_ready", 64'(o_job_ready), 64'd1);
        checkOutput("t5_res_valid", 64'(o_res_valid), 64'd0);
        checkOutput("t5_pe_valid", 64'(o_pe_valid), 64'd0);
        peReturn(stale1, 6'd5, 1'b1);
        peReturn(stale2, 6'd5, 1'b1);
        checkOutput("t5_stale_ignored", 64'(o_res_valid), 64'd0);
        tick();
        checkOutput("t5_stale_ignored2", 64'(o_res_valid), 64'd0);
        applyStimulus(16'h5200, mkHist(16'hE200), 4'b0001, idx);
        checkOutput("t5_entry0", 64'(o_pe_idx), 64'd0);
        pushRes(6'd3, 2'd0, 16'hE200);
        peReturn(idx, 6'd3, 1'b1);
        repeat (4) tick();

`ifdef MATCH_SB_STATS_EN
        // Statistics: three jobs with lengths 0, 5, 0
        $display("[TB] statistics counters");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tb_alloc = 0;
        for (int j = 0; j < 3; j++) begin
            applyStimulus(16'h6000 + AW'(j), mkHist(16'hF000 + AW'(j * 16)), 4'b0001, idx);
            pushRes((j == 1) ? 6'd5 : 6'd0, 2'd0, 16'hF000 + AW'(j * 16));
            peReturn(idx, (j == 1) ? 6'd5 : 6'd0, 1'b1);
        end
        repeat (6) tick();
        checkOutput("stat_jobs", 64'(o_stat_jobs), 64'd3);
        checkOutput("stat_zero", 64'(o_stat_zero), 64'd2);
`endif

        checkOutput("pe_queue_drained", 64'(pe_q.size()), 64'd0);
        checkOutput("res_queue_drained", 64'(res_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
